instr_decode: RTL and testbench
===============================

# instr_decode

Fetch/decode sequencer sitting directly downstream of the instruction memory in the finder core. It consumes the byte stream on `instr` and drives the memory's `next_instr`, `jump`, `opcode` and `jdata` inputs. It assembles multi-byte jump instructions, resolves absolute and relative jumps, and hands all other instructions to the execution unit over a valid/ready handshake.

## Interface
- `WIDTH_INSTR`, 8: instruction word width; opcode is `[WIDTH_INSTR-1 -: WIDTH_OPCODE]`.
- `WIDTH_OPCODE`, 4: opcode width.
- `WIDTH_JDATA`, 24: jump operand width; must be a multiple of `WIDTH_INSTR` (NARG = `WIDTH_JDATA/WIDTH_INSTR`, 3 by default).
- `RAM_LAT`, 1: wait cycles, ≥1, between an address-advance pulse and a valid `instr`.
- `clk` in 1: clock, all logic on posedge.
- `rst` in 1: asynchronous, active-high reset; the top ties the memory's `rstn = ~rst`.
- `instr` in `WIDTH_INSTR`: word from instruction memory.
- `next_instr` out 1: single-cycle pulse that advances the memory address by 1.
- `jump` out 1: single-cycle pulse that loads the jump target into the memory.
- `opcode` out `WIDTH_OPCODE`: registered opcode of the current instruction.
- `jdata` out `WIDTH_JDATA`: assembled jump operand.
- `flag` in 1: condition for relative jumps, sampled in JUMP.
- `exec_valid` out 1: non-jump instruction available.
- `exec_ready` in 1: execution unit accepts.
- `exec_op` out `WIDTH_OPCODE`: opcode for the execution unit.
- `exec_arg` out `WIDTH_INSTR-WIDTH_OPCODE`: low field of the instruction word.
- `illegal` out 1: sticky reserved-opcode trap; see Configuration.

## Operation
- The FSM has five states: WAIT, OP, ARG, EXEC, JUMP. Reset state is WAIT with the wait counter set to `RAM_LAT`. The return target after WAIT is OP.
- **WAIT:** count down `RAM_LAT` cycles, then go to the return target.
- **OP:** sample `instr` and register `opcode`.
  - Opcode 4'b1010 (absolute) or 4'b1001 (relative): clear `jdata`, load the arg counter with NARG, pulse `next_instr`, go to WAIT and return to ARG.
  - Any other opcode: load `exec_op`/`exec_arg`, set `exec_valid`, go to EXEC.
- **EXEC:** hold `exec_valid`, `exec_op` and `exec_arg` stable until `exec_valid && exec_ready`. On that cycle, drop `exec_valid`, pulse `next_instr`, go to WAIT and return to OP.
- **ARG:** place `instr` into `jdata`, LSB byte first (k-th arg byte → bits `[k*WIDTH_INSTR +: WIDTH_INSTR]`), then decrement the counter.
  - Counter not at its last byte: pulse `next_instr`, go to WAIT and return to ARG.
  - Last byte: go to JUMP.
- **JUMP:**
  - 1010: pulse `jump`. The memory loads `jdata[WIDTH_ADDR-1:0]`.
  - 1001 with `flag`=1: pulse `jump`. The new address is the last-arg-byte address + `jdata[7:0]`, unsigned, modulo 2^WIDTH_ADDR; wrap-around is legal.
  - 1001 with `flag`=0: pulse `next_instr` instead.
  - In all cases, go to WAIT and return to OP.
- `next_instr` and `jump` are never asserted in the same cycle, and never for more than one cycle.
- `opcode` and `jdata` hold their values until the next OP/ARG capture. They are stable whenever `jump` is high.

## Timing
- All outputs reset to 0: `next_instr`, `jump`, `opcode`, `jdata`, `exec_valid`, `exec_op`, `exec_arg`, `illegal`.
- First `instr` sample happens `RAM_LAT`+1 cycles after `rst` deasserts (cycle 2 for `RAM_LAT`=1).
- Single-byte instruction: `exec_valid` rises on the cycle after OP. The fetch of the following instruction starts in the handshake cycle.
- Throughput with `RAM_LAT`=1 and `exec_ready` held high: one single-byte instruction per 3 cycles.
- Jump instruction: 1 OP + NARG ARG samples. That is NARG `next_instr` pulses, then one `jump`/`next_instr` pulse in JUMP.
- `rst` mid-operation (any state): asynchronous return to reset values. A partially assembled `jdata` is discarded and no pulse is emitted.
- If `exec_ready` is high before `exec_valid`, it is ignored.

## Configuration
- Macro `INSTR_DECODE_ILLEGAL_TRAP_EN`:
  - **Defined:** opcodes 4'b1011–4'b1111 are reserved. In OP such an opcode sets `illegal`=1, which is sticky until `rst`. The FSM then halts, with no further `next_instr`, `jump` or `exec_valid`.
  - **Undefined:** reserved opcodes are forwarded to EXEC like any other opcode, and `illegal` is tied 0.

## Test plan
- **Single-byte handshake:** memory[0]=0x35, `exec_ready`=0 for 4 cycles then 1. Expect `exec_valid`=1, `exec_op`=3, `exec_arg`=5, all stable for 4 cycles. Expect one `next_instr` pulse on the handshake cycle, then a fetch from address 1.
- **Absolute jump:** memory[0..3]=0xA0,0x10,0x00,0x00. Expect 3 `next_instr` pulses, then `jump`=1 for one cycle with `opcode`=4'hA and `jdata`=0x000010. Expect the next OP sample to come from address 0x10.
- **Relative jump taken:** memory[4..7]=0x90,0x03,0x00,0x00, `flag`=1. Expect `jump` pulse with `jdata`=0x000003 and the next fetch from address 10.
- **Relative jump not taken:** same program, `flag`=0. Expect no `jump`, one `next_instr` in JUMP, and the next fetch from address 8.
- **Reset mid-operation:** assert `rst` in ARG after the second arg byte. Expect all outputs 0 immediately. After release, expect a fetch from address 0 and a clean re-decode.
- **Reserved opcode:** memory[0]=0xB2.
  - With the macro: expect `illegal`=1 held, with no `exec_valid`, `next_instr` or `jump` for 20 cycles.
  - Without the macro: expect `exec_valid` with `exec_op`=4'hB and `exec_arg`=2.

Source files
------------

// File: rtl/instr_decode.sv
// instr_decode: fetch/decode sequencer downstream of the instruction memory.
// Assembles multi-byte jump instructions (LSB byte first), resolves absolute
// and relative jumps, and forwards every other instruction to the execution
// unit over a valid/ready handshake.
// Optional feature macro: INSTR_DECODE_ILLEGAL_TRAP_EN (reserved-opcode trap).
module instr_decode #(
    parameter int WIDTH_INSTR  = 8,
    parameter int WIDTH_OPCODE = 4,
    parameter int WIDTH_JDATA  = 24,
    parameter int RAM_LAT      = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [WIDTH_INSTR-1:0]              instr,
    output logic                                next_instr,
    output logic                                jump,
    output logic [WIDTH_OPCODE-1:0]             opcode,
    output logic [WIDTH_JDATA-1:0]              jdata,
    input  logic                                flag,
    output logic                                exec_valid,
    input  logic                                exec_ready,
    output logic [WIDTH_OPCODE-1:0]             exec_op,
    output logic [WIDTH_INSTR-WIDTH_OPCODE-1:0] exec_arg,
    output logic                                illegal
);

    localparam int NARG      = WIDTH_JDATA / WIDTH_INSTR;
    localparam int WIDTH_ARG = WIDTH_INSTR - WIDTH_OPCODE;
    localparam int WC_W      = (RAM_LAT > 1) ? $clog2(RAM_LAT + 1) : 1;
    localparam int AC_W      = $clog2(NARG + 1);

    localparam logic [WIDTH_OPCODE-1:0] OPC_ABS = WIDTH_OPCODE'(10);
    localparam logic [WIDTH_OPCODE-1:0] OPC_REL = WIDTH_OPCODE'(9);

    typedef enum logic [2:0] {
        S_WAIT,
        S_OP,
        S_ARG,
        S_EXEC,
        S_JUMP
    } state_t;

    state_t state_q, state_d;
    state_t ret_q, ret_d;
    logic [WC_W-1:0] wcnt_q, wcnt_d;
    logic [AC_W-1:0] acnt_q, acnt_d;

    logic [WIDTH_OPCODE-1:0] opcode_d;
    logic [WIDTH_JDATA-1:0]  jdata_d;
    logic                    exec_valid_d;
    logic [WIDTH_OPCODE-1:0] exec_op_d;
    logic [WIDTH_ARG-1:0]    exec_arg_d;

    logic [WIDTH_OPCODE-1:0] op_in;
    logic                    is_jump;
    logic                    halt;

    assign op_in   = instr[WIDTH_INSTR-1 -: WIDTH_OPCODE];
    assign is_jump = (op_in == OPC_ABS) || (op_in == OPC_REL);

`ifdef INSTR_DECODE_ILLEGAL_TRAP_EN
    localparam logic [WIDTH_OPCODE-1:0] OPC_RSVD_LO = WIDTH_OPCODE'(11);
    logic illegal_q, illegal_d;
    assign illegal = illegal_q;
    // Once trapped the sequencer freezes until reset.
    assign halt    = illegal_q;
`else
    assign illegal = 1'b0;
    assign halt    = 1'b0;
`endif

    // Next-state and pulse outputs; pulses are combinational so the memory
    // sees them on the same edge that leaves the deciding state.
    always_comb begin
        int arg_idx;
        state_d      = state_q;
        ret_d        = ret_q;
        wcnt_d       = wcnt_q;
        acnt_d       = acnt_q;
        opcode_d     = opcode;
        jdata_d      = jdata;
        exec_valid_d = exec_valid;
        exec_op_d    = exec_op;
        exec_arg_d   = exec_arg;
        next_instr   = 1'b0;
        jump         = 1'b0;
        arg_idx      = NARG - int'(acnt_q);
`ifdef INSTR_DECODE_ILLEGAL_TRAP_EN
        illegal_d    = illegal_q;
`endif
        if (!halt) begin
            case (state_q)
                S_WAIT: begin
                    if (wcnt_q <= WC_W'(1)) state_d = ret_q;
                    else                    wcnt_d  = wcnt_q - WC_W'(1);
                end
                S_OP: begin
                    opcode_d = op_in;
`ifdef INSTR_DECODE_ILLEGAL_TRAP_EN
                    if (op_in >= OPC_RSVD_LO) begin
                        illegal_d = 1'b1;
                    end else
`endif
                    if (is_jump) begin
                        jdata_d    = '0;
                        acnt_d     = AC_W'(NARG);
                        next_instr = 1'b1;
                        state_d    = S_WAIT;
                        ret_d      = S_ARG;
                        wcnt_d     = WC_W'(RAM_LAT);
                    end else begin
                        exec_op_d    = op_in;
                        exec_arg_d   = instr[WIDTH_ARG-1:0];
                        exec_valid_d = 1'b1;
                        state_d      = S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_valid && exec_ready) begin
                        exec_valid_d = 1'b0;
                        next_instr   = 1'b1;
                        state_d      = S_WAIT;
                        ret_d        = S_OP;
                        wcnt_d       = WC_W'(RAM_LAT);
                    end
                end
                S_ARG: begin
                    for (int k = 0; k < NARG; k++)
                        if (k == arg_idx) jdata_d[k*WIDTH_INSTR +: WIDTH_INSTR] = instr;
                    acnt_d = acnt_q - AC_W'(1);
                    if (acnt_q == AC_W'(1)) begin
                        state_d = S_JUMP;
                    end else begin
                        next_instr = 1'b1;
                        state_d    = S_WAIT;
                        ret_d      = S_ARG;
                        wcnt_d     = WC_W'(RAM_LAT);
                    end
                end
                S_JUMP: begin
                    // Untaken relative jump just steps past the last arg byte.
                    if (opcode == OPC_ABS || flag) jump       = 1'b1;
                    else                           next_instr = 1'b1;
                    state_d = S_WAIT;
                    ret_d   = S_OP;
                    wcnt_d  = WC_W'(RAM_LAT);
                end
                default: state_d = S_WAIT;
            endcase
        end
    end

    // State and datapath registers; reset discards any partial jump operand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_WAIT;
            ret_q      <= S_OP;
            wcnt_q     <= WC_W'(RAM_LAT);
            acnt_q     <= '0;
            opcode     <= '0;
            jdata      <= '0;
            exec_valid <= 1'b0;
            exec_op    <= '0;
            exec_arg   <= '0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            wcnt_q     <= wcnt_d;
            acnt_q     <= acnt_d;
            opcode     <= opcode_d;
            jdata      <= jdata_d;
            exec_valid <= exec_valid_d;
            exec_op    <= exec_op_d;
            exec_arg   <= exec_arg_d;
        end
    end

`ifdef INSTR_DECODE_ILLEGAL_TRAP_EN
    // Sticky reserved-opcode trap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) illegal_q <= 1'b0;
        else     illegal_q <= illegal_d;
    end
`endif

endmodule

// File: tb/tb_instr_decode.sv
// tb_instr_decode: randomized bench for instr_decode with a byte-addressed
// instruction memory model and an instruction-level reference interpreter
// that predicts the ordered stream of pulses/handshakes and their spacing.
module tb_instr_decode;

    localparam int WI = 8, WO = 4, WJ = 24, L = 1, NARG = WJ / WI;

    logic          clk = 1'b0, rst = 1'b1;
    logic [WI-1:0] instr;
    logic          next_instr, jump, exec_valid, illegal;
    logic          flag = 1'b0, exec_ready = 1'b0;
    logic [WO-1:0] opcode, exec_op;
    logic [WJ-1:0] jdata;
    logic [WI-WO-1:0] exec_arg;

    instr_decode #(.WIDTH_INSTR(WI), .WIDTH_OPCODE(WO), .WIDTH_JDATA(WJ), .RAM_LAT(L)) dut (
        .clk(clk), .rst(rst), .instr(instr), .next_instr(next_instr), .jump(jump),
        .opcode(opcode), .jdata(jdata), .flag(flag), .exec_valid(exec_valid),
        .exec_ready(exec_ready), .exec_op(exec_op), .exec_arg(exec_arg), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Instruction memory: registered read, one wait cycle after an address change.
    logic [7:0] mem [0:255];
    logic [7:0] maddr;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            maddr <= 8'h00;
            instr <= 8'h00;
        end else begin
            if (next_instr)  maddr <= maddr + 8'd1;
            else if (jump)   maddr <= (opcode == 4'hA) ? jdata[7:0] : maddr + jdata[7:0];
            instr <= mem[maddr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_NEXT, EV_JUMP, EV_REL, EV_VALID, EV_ILL} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [3:0] op;
        logic [3:0] arg;
        logic [23:0] jd;
        int         dly;
        bit         hs;
    } ev_t;

    ev_t exq[$];
    int tests = 0, fails = 0;
    int last_pulse = 0, idle = 0;
    logic [7:0] pc = 8'h00;
    bit halted = 0, evt = 0;
    bit prev_valid = 0, prev_ready = 0, prev_pulse = 0, prev_ill = 0;
    logic [3:0] prev_op, prev_arg;
    int n_next = 0, n_jump = 0, n_hs = 0, n_valid = 0, nj_next = 0;
    logic [3:0] hs_op = 0, hs_arg = 0, j_op = 0;
    logic [23:0] j_jd = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic ev_t mk(ev_kind_t k, logic [3:0] op, logic [3:0] arg,
                               logic [23:0] jd, int dly, bit hs);
        ev_t e;
        e.kind = k; e.op = op; e.arg = arg; e.jd = jd; e.dly = dly; e.hs = hs;
        return e;
    endfunction

    // Interpret the instruction at pc and queue the events it must produce.
    task automatic gen_instr();
        logic [7:0] b;
        logic [3:0] op;
        logic [23:0] jd;
        b  = mem[pc];
        op = b[7:4];
        jd = {mem[pc + 8'd3], mem[pc + 8'd2], mem[pc + 8'd1]};
        if (op == 4'hA || op == 4'h9) begin
            for (int i = 0; i < NARG; i++) exq.push_back(mk(EV_NEXT, op, 0, 0, L + 1, 0));
            exq.push_back(mk(op == 4'hA ? EV_JUMP : EV_REL, op, 0, jd, L + 2, 0));
            if (op == 4'hA) pc = jd[7:0];
        end
`ifdef INSTR_DECODE_ILLEGAL_TRAP_EN
        else if (op >= 4'hB) begin
            exq.push_back(mk(EV_ILL, op, 0, 0, L + 2, 0));
            halted = 1;
        end
`endif
        else begin
            exq.push_back(mk(EV_VALID, op, b[3:0], 0, L + 2, 0));
            exq.push_back(mk(EV_NEXT, op, 0, 0, -1, 1));
            pc = pc + 8'd1;
        end
    endtask

    task automatic observe(input ev_kind_t k);
        ev_t e;
        ev_kind_t ek;
        int d;
        d   = cyc - last_pulse;
        evt = 1;
        if (exq.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_event: actual kind %0d, required none (cycle %0d)", k, cyc);
        end else begin
            e  = exq.pop_front();
            ek = e.kind;
            if (ek == EV_REL) ek = flag ? EV_JUMP : EV_NEXT;
            check("event_kind", k, ek);
            if (k == ek) begin
                case (k)
                    EV_JUMP:  check("jump_op_jdata", {opcode, jdata}, {e.op, e.jd});
                    EV_VALID: check("exec_op_arg", {exec_op, exec_arg}, {e.op, e.arg});
                    EV_NEXT:  if (e.hs) check("next_on_handshake", exec_valid && exec_ready, 1);
                    default: ;
                endcase
                if (e.dly >= 0) check("event_spacing", d, e.dly);
            end
            if (e.kind == EV_REL)
                pc = flag ? pc + 8'(NARG) + e.jd[7:0] : pc + 8'(NARG + 1);
        end
        case (k)
            EV_NEXT: begin
                n_next++;
                if (exec_valid && exec_ready) begin
                    n_hs++; hs_op = exec_op; hs_arg = exec_arg;
                end
            end
            EV_JUMP:  begin n_jump++; j_jd = jdata; j_op = opcode; nj_next = n_next; end
            EV_VALID: n_valid++;
            default: ;
        endcase
        if (k == EV_NEXT || k == EV_JUMP) last_pulse = cyc;
    endtask

    // Single compare process, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            check("reset_outputs", {next_instr, jump, opcode, jdata, exec_valid, exec_op, exec_arg, illegal}, 0);
            exq.delete();
            pc = 0; halted = 0; last_pulse = cyc; idle = 0;
            prev_valid = 0; prev_ready = 0; prev_pulse = 0; prev_ill = 0;
            n_next = 0; n_jump = 0; n_hs = 0; n_valid = 0; nj_next = 0;
        end else begin
            evt = 0;
            if (exq.size() == 0 && !halted) gen_instr();
            if (prev_valid && !prev_ready)
                check("exec_hold", {exec_valid, exec_op, exec_arg}, {1'b1, prev_op, prev_arg});
            check("pulse_exclusive", next_instr & jump, 0);
            check("pulse_single_cycle", prev_pulse & (next_instr | jump), 0);
`ifdef INSTR_DECODE_ILLEGAL_TRAP_EN
            if (prev_ill) check("illegal_sticky", illegal, 1);
            if (illegal && !prev_ill) observe(EV_ILL);
`else
            check("illegal_tied", illegal, 0);
`endif
            if (exec_valid && !prev_valid) observe(EV_VALID);
            if (jump)            observe(EV_JUMP);
            else if (next_instr) observe(EV_NEXT);
            if (evt) idle = 0;
            else if (exq.size() != 0 || !halted) idle++;
            if (idle > 100) begin
                tests++; fails++;
                $display("FAIL stall: no event for %0d cycles, required progress (cycle %0d)", idle, cyc);
                idle = 0;
            end
            prev_valid = exec_valid; prev_ready = exec_ready;
            prev_op = exec_op; prev_arg = exec_arg;
            prev_pulse = next_instr | jump; prev_ill = illegal;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold_rst();
        rst = 1'b1;
        tick(2);
    endtask

    task automatic release_rst();
        tick(1);
        rst = 1'b0;
    endtask

    task automatic fill_default();
        for (int i = 0; i < 256; i++) mem[i] = 8'h01;
    endtask

    task automatic wait_cnt(input string name, input int which, input int n);
        int b = 0;
        while (((which == 0) ? n_hs : n_next) < n && b < 500) begin
            tick(); b++;
        end
        if (((which == 0) ? n_hs : n_next) < n) begin
            tests++; fails++;
            $display("FAIL %s: timeout, actual count %0d required %0d", name,
                     (which == 0) ? n_hs : n_next, n);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        fill_default();
        tick(3);

        // Single-byte handshake with back-pressure.
        mem[0] = 8'h35; mem[1] = 8'h47;
        exec_ready = 0;
        release_rst();
        begin
            int b = 0;
            while (!exec_valid && b < 50) begin tick(); b++; end
        end
        check("hs_valid_first", {exec_valid, exec_op, exec_arg}, 9'h135);
        tick(4);
        check("hs_valid_held", {exec_valid, exec_op, exec_arg}, 9'h135);
        exec_ready = 1;
        wait_cnt("hs_second", 0, 2);
        check("hs_fetch_addr1", {hs_op, hs_arg}, 8'h47);

        // Absolute jump.
        hold_rst(); fill_default();
        mem[0] = 8'hA0; mem[1] = 8'h10; mem[2] = 8'h00; mem[3] = 8'h00; mem[8'h10] = 8'h6C;
        release_rst();
        wait_cnt("abs_target", 0, 1);
        check("abs_next_before_jump", nj_next, 3);
        check("abs_jump_op", j_op, 4'hA);
        check("abs_jdata", j_jd, 24'h000010);
        check("abs_target_instr", {hs_op, hs_arg}, 8'h6C);

        // Relative jump taken / not taken.
        for (int t = 1; t >= 0; t--) begin
            hold_rst(); fill_default();
            mem[0] = 8'h11; mem[1] = 8'h12; mem[2] = 8'h13; mem[3] = 8'h14;
            mem[4] = 8'h90; mem[5] = 8'h03; mem[6] = 8'h00; mem[7] = 8'h00;
            mem[8] = 8'h2B; mem[10] = 8'h5A;
            flag = t[0];
            release_rst();
            wait_cnt("rel_after", 0, 5);
            check("rel_jump_count", n_jump, t);
            check("rel_next_instr", {hs_op, hs_arg}, t ? 8'h5A : 8'h2B);
            if (t == 1) check("rel_jdata", j_jd, 24'h000003);
        end
        flag = 0;

        // Reset in the middle of operand assembly.
        hold_rst(); fill_default();
        mem[0] = 8'hA0; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h00; mem[8'h22] = 8'h77;
        release_rst();
        wait_cnt("mid_args", 1, 3);
        tick(1);
        check("partial_jdata", jdata, 24'h003322);
        rst = 1'b1;
        #1;
        check("rst_async", {next_instr, jump, opcode, jdata, exec_valid}, 0);
        tick(2);
        rst = 1'b0;
        wait_cnt("redecode", 0, 1);
        check("redecode_jdata", j_jd, 24'h003322);
        check("redecode_instr", {hs_op, hs_arg}, 8'h77);

        // Reserved opcode.
        hold_rst(); fill_default();
        mem[0] = 8'hB2;
        release_rst();
`ifdef INSTR_DECODE_ILLEGAL_TRAP_EN
        tick(25);
        check("trap_illegal", illegal, 1);
        check("trap_quiet", n_next + n_jump + n_valid, 0);
`else
        wait_cnt("rsvd_exec", 0, 1);
        check("rsvd_forwarded", {hs_op, hs_arg}, 8'hB2);
`endif

        // Randomized program, back-pressure, flag and resets.
        hold_rst();
        for (int i = 0; i < 256; i++) begin
            int r;
            logic [3:0] op;
            r = $urandom_range(0, 99);
            if (r < 2)       op = 4'($urandom_range(11, 15));
            else if (r < 20) op = ($urandom_range(0, 1) != 0) ? 4'hA : 4'h9;
            else             op = 4'($urandom_range(0, 8));
            mem[i] = {op, 4'($urandom_range(0, 15))};
        end
        release_rst();
        for (int i = 0; i < 4000; i++) begin
            exec_ready = ($urandom_range(0, 9) < 7);
            flag       = ($urandom_range(0, 1) != 0);
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                tick($urandom_range(1, 3));
                rst = 1'b0;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
